// File: rtl/sram_pkg.sv
// sram_pkg: geometry constants shared by the data and tag SRAM macros
package sram_pkg;

    function automatic int ceil_log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DATA_DEPTH     = 64;
    localparam int DATA_WIDTH     = 128;
    localparam int DATA_ADDR_BITS = ceil_log2(DATA_DEPTH);
    localparam int TAG_DEPTH      = 16;
    localparam int TAG_WIDTH      = 32;
    localparam int TAG_ADDR_BITS  = ceil_log2(TAG_DEPTH);

endpackage

// File: rtl/sram_port.sv
// sram_port: one synchronous SRAM port; decodes the access, owns the output register and OEB gating
module sram_port #(
    parameter int DEPTH     = 64,
    parameter int WIDTH     = 128,
    parameter int ADDR_BITS = 6
) (
    input  logic                 ce_i,
    input  logic                 rst_i,
    input  logic                 csb_i,
    input  logic                 web_i,
    input  logic                 oeb_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [WIDTH-1:0]     arr_rdata_i,
    output logic                 wr_en_o,
    output logic [WIDTH-1:0]     dout_o
);

    logic             in_range;
    logic             rd_en;
    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;

    // Extra MSB keeps the range test meaningful when DEPTH fills the address space.
    assign in_range = {1'b0, addr_i} < (ADDR_BITS + 1)'(DEPTH);
    assign wr_en_o  = !csb_i && !web_i && in_range;
    assign rd_en    = !csb_i && web_i;

    // Next output register value: load on read (zero when out of range), otherwise hold.
    always_comb begin
        dout_d = rd_en ? (in_range ? arr_rdata_i : '0) : dout_q;
    end

    // Output register, cleared immediately by the asynchronous reset.
    always_ff @(posedge ce_i or posedge rst_i) begin
        if (rst_i) dout_q <= '0;
        else       dout_q <= dout_d;
    end

    assign dout_o = oeb_i ? '0 : dout_q;

endmodule

// File: rtl/sram_1rw_64x128.sv
// sram_1rw_64x128: single-port 64x128 synchronous SRAM model with asynchronous clear, L1 data way
module sram_1rw_64x128
    import sram_pkg::*;
(
    input  logic                      CE,
    input  logic                      reset,
    input  logic                      WEB,
    input  logic                      OEB,
    input  logic                      CSB,
    input  logic [DATA_ADDR_BITS-1:0] A,
    input  logic [DATA_WIDTH-1:0]     I,
    output logic [DATA_WIDTH-1:0]     O
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic                  wr_en;

    sram_port #(
        .DEPTH     (DATA_DEPTH),
        .WIDTH     (DATA_WIDTH),
        .ADDR_BITS (DATA_ADDR_BITS)
    ) u_port (
        .ce_i        (CE),
        .rst_i       (reset),
        .csb_i       (CSB),
        .web_i       (WEB),
        .oeb_i       (OEB),
        .addr_i      (A),
        .arr_rdata_i (mem_q[A]),
        .wr_en_o     (wr_en),
        .dout_o      (O)
    );

    // Storage array: full-word writes, whole array cleared by reset for deterministic start-up.
    always_ff @(posedge CE or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DATA_DEPTH; k++) mem_q[k] <= '0;
        end else if (wr_en) begin
            mem_q[A] <= I;
        end
    end

endmodule

// File: tb/tb_sram_1rw_64x128.sv
// tb_sram_1rw_64x128: directed bench with a word-array reference model checked every cycle
module tb_sram_1rw_64x128;

    logic         CE    = 1'b0;
    logic         reset = 1'b1;
    logic         WEB   = 1'b1;
    logic         OEB   = 1'b0;
    logic         CSB   = 1'b1;
    logic [5:0]   A     = '0;
    logic [127:0] I     = '0;
    logic [127:0] O;

    int tests = 0;
    int fails = 0;

    logic [127:0] m_mem [64];
    logic [127:0] m_q;

    localparam logic [127:0] V    = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] P5A  = {16{8'h5A}};

    sram_1rw_64x128 dut (
        .CE    (CE),
        .reset (reset),
        .WEB   (WEB),
        .OEB   (OEB),
        .CSB   (CSB),
        .A     (A),
        .I     (I),
        .O     (O)
    );

    always #5 CE = ~CE;

    // Reference: a plain array plus the last read word.
    always @(posedge CE or posedge reset) begin
        if (reset) begin
            m_q <= '0;
            for (int k = 0; k < 64; k++) m_mem[k] <= '0;
        end else if (!CSB) begin
            if (!WEB) m_mem[A] <= I;
            else      m_q <= m_mem[A];
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Every cycle out of reset the output must match the model.
    always @(negedge CE) if (!reset) check("model", O, OEB ? 128'h0 : m_q);

    task automatic cyc(input logic c, input logic w, input logic [5:0] a, input logic [127:0] d);
        CSB = c;
        WEB = w;
        A   = a;
        I   = d;
        @(negedge CE);
    endtask

    initial begin
        repeat (2) @(negedge CE);
        reset = 1'b0;
        check("reset_O", O, 128'h0);

        cyc(1'b0, 1'b0, 6'd5, 128'hFF);
        cyc(1'b0, 1'b1, 6'd5, '0);
        check("pre_rd5", O, 128'hFF);
        #1 reset = 1'b1;
        #1 check("async_clr_O", O, 128'h0);
        #1 reset = 1'b0;
        cyc(1'b0, 1'b1, 6'd5, '0);
        check("rd5_after_rst", O, 128'h0);

        cyc(1'b0, 1'b0, 6'd3, V);
        check("wr3_no_thru", O, 128'h0);
        cyc(1'b0, 1'b1, 6'd3, '0);
        check("rd3", O, V);
        cyc(1'b0, 1'b0, 6'd4, ~V);
        check("wr4_hold", O, V);
        cyc(1'b0, 1'b1, 6'd4, '0);
        check("rd4", O, ~V);

        cyc(1'b0, 1'b0, 6'd0, ONES);
        cyc(1'b0, 1'b0, 6'd63, P5A);
        cyc(1'b0, 1'b1, 6'd0, '0);
        check("rd0", O, ONES);
        cyc(1'b0, 1'b1, 6'd63, '0);
        check("rd63", O, P5A);
        cyc(1'b0, 1'b1, 6'd1, '0);
        check("rd1", O, 128'h0);
        cyc(1'b0, 1'b1, 6'd62, '0);
        check("rd62", O, 128'h0);

        cyc(1'b1, 1'b0, 6'd7, ONES);
        cyc(1'b0, 1'b1, 6'd7, '0);
        check("csb_block", O, 128'h0);
        cyc(1'b0, 1'b1, 6'd3, '0);
        check("rd3_again", O, V);
        cyc(1'b1, 1'b1, 6'd0, '0);
        cyc(1'b1, 1'b0, 6'd0, '0);
        check("idle_hold", O, V);

        OEB = 1'b1;
        #1 check("oeb_off", O, 128'h0);
        OEB = 1'b0;
        #1 check("oeb_on", O, V);

        for (int k = 0; k < 8; k++)
            cyc(1'b0, 1'b0, 6'(k * 9), {4{32'(k) * 32'h0101_0101}});
        for (int k = 7; k >= 0; k--) begin
            cyc(1'b0, 1'b1, 6'(k * 9), '0);
            check("pattern", O, {4{32'(k) * 32'h0101_0101}});
        end

        CSB = 1'b0;
        WEB = 1'b0;
        A   = 6'd9;
        I   = 128'h1;
        #2 reset = 1'b1;
        @(negedge CE);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 6'd9, '0);
        check("rst_during_wr", O, 128'h0);
        cyc(1'b0, 1'b1, 6'd3, '0);
        check("rst_clears_3", O, 128'h0);

        cyc(1'b1, 1'b1, 6'd0, '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_1rw_64x128.md
Name: sram_1rw_64x128

Overview:
- Behavioural model of a single-port synchronous SRAM macro: 64 words x 128 bits.
- Used as the per-way data array of the L1 cache; one 128-bit memory beat is stored per word.
- Macro-style active-low controls (WEB, OEB, CSB) match the foundry pin naming used elsewhere in the codebase.
- Has an added asynchronous reset so that cache start-up contents are deterministic.

Parameters:
- DEPTH, 64, number of words.
- WIDTH, 128, bits per word.
- ADDR_BITS, 6, address width; must equal ceilLog2(DEPTH).

Ports:
- CE  input  1  clock (macro clock-edge pin); all sampling on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- WEB  input  1  write-enable bar: 0 = write, 1 = read.
- OEB  input  1  output-enable bar: 0 = O driven from the output register, 1 = O forced to zero.
- CSB  input  1  chip-select bar: 0 = access enabled, 1 = idle.
- A  input  ADDR_BITS  word address.
- I  input  WIDTH  write data.
- O  output  WIDTH  read data.

Behaviour:
- One clock (CE); reset is asynchronous and active-high; everything else is synchronous to the CE rising edge.
- Reset asserted, at any time including mid-access:
  - output register cleared to 0 immediately;
  - all DEPTH array words cleared to 0;
  - a CE edge while reset is high performs no access.
- CE rising edge, reset low, CSB = 1: no access; array and output register hold.
- CE rising edge, reset low, CSB = 0, WEB = 0 (write):
  - mem[A] <= I, full-word write with no byte mask;
  - output register holds its previous value (no write-through to O).
- CE rising edge, reset low, CSB = 0, WEB = 1 (read):
  - output register <= mem[A];
  - read latency is exactly 1 cycle: the address presented before edge N appears on O after edge N.
- O = output register when OEB = 0, else all zeros. O is combinational on OEB and never tristates.
- Output register holds between reads, so repeated idle cycles keep the last read data.
- Address range: A is always < DEPTH when DEPTH = 2^ADDR_BITS, so no out-of-range handling is needed. If DEPTH < 2^ADDR_BITS, out-of-range writes are dropped and out-of-range reads return 0.
- Inputs change freely between edges; only values at the CE edge matter.
- No read-modify-write: byte merging is done by the client, which presents the full merged word on I.
- Sibling macro sram_2rw_16x32 (tag/valid array, 16x32, two independent ports):
  - ports CE1/CE2, WEB1/2, OEB1/2, CSB1/2, A1/2, I1/2, O1/2, plus the same reset;
  - identical per-port rules;
  - same-address write/write collision on one edge: port 1 wins;
  - same-address read/write on one edge: the read returns the old data.

Decomposition:
- Shared package sram_pkg holds the geometry constants:
  - DATA_DEPTH = 64, DATA_WIDTH = 128;
  - TAG_DEPTH = 16, TAG_WIDTH = 32;
  - ceilLog2-derived address widths.
- One natural sub-module: sram_port, one synchronous read/write port with output register and OEB gating.
  - sram_1rw_64x128 instantiates it once.
  - sram_2rw_16x32 instantiates it twice over a shared array, with the port-1-wins arbitration done in the wrapper.

Test Plan:
- Reset then read: assert reset mid-cycle, release; CSB=0, WEB=1, A=5 -> O=0 one edge later; O is already 0 before the first edge after reset.
- Write then read back: write A=3, I=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677; on the next edge read A=3 -> O equals that value exactly one edge later; O unchanged during the write cycle.
- Boundary addresses: write A=0 with all-ones and A=63 with 128'h5A repeated; read both -> exact values; A=1 and A=62 still 0.
- CSB=1 blocks access: with CSB=1, WEB=0, A=7, I=all-ones, then read A=7 with CSB=0 -> O=0. Also an idle CSB=1 edge leaves O holding the prior read value.
- OEB gating: after reading nonzero data at A=3, raise OEB -> O=0 combinationally; lower OEB -> previous data reappears with no new edge.
- Async reset during a write: write A=9 with 128'h1 and assert reset before the edge; release, then read A=9 -> O=0.
